// File: rtl/sram_banked_2p_wrap_pkg.sv
// Shared types and sizing helpers for the depth-banked two-port SRAM wrapper.
package sram_banked_2p_wrap_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int MAX_BANKS = 16;

    // ceil(log2(n)), never below 1 so a single-bank build still has an index bit
    function automatic int log2c(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int nbanks(input int aw, input int baw);
        return 1 << (aw - baw);
    endfunction

endpackage

// File: rtl/sram_sp_bank.sv
// One single-port bank: write or read per enabled cycle, 1-cycle registered read.
// No backpressure; the caller owns arbitration.
module sram_sp_bank #(
    parameter int DWidth = 64,
    parameter int AWidth = 10
) (
    input  logic              Clock,
    input  logic              Enable,
    input  logic              Write,
    input  logic [AWidth-1:0] Address,
    input  logic [DWidth-1:0] DIn,
    output logic [DWidth-1:0] DOut
);

    logic [DWidth-1:0] mem_q [2**AWidth];
    logic [DWidth-1:0] dout_q;

    always_ff @(posedge Clock) begin
        if (Enable) begin
            if (Write) mem_q[Address] <= DIn;
            else       dout_q <= mem_q[Address];
        end
    end

    assign DOut = dout_q;

endmodule

// File: rtl/sram_banked_2p_wrap.sv
// Depth-banked read/write memory; read latency 1 + OutReg, different-bank requests both complete.
// Same-bank conflicts alternate by a priority bit; no output backpressure.
module sram_banked_2p_wrap
    import sram_banked_2p_wrap_pkg::*;
#(
    parameter int DWidth     = 64,
    parameter int AWidth     = 12,
    parameter int BankAWidth = 10,
    parameter int OutReg     = 1,
    parameter int ZeroInit   = 1
) (
    input  logic              Clock,
    input  logic              Reset_N,
    input  logic              ReadValid,
    output logic              ReadReady,
    input  logic [AWidth-1:0] ReadAddress,
    input  logic              WriteValid,
    output logic              WriteReady,
    input  logic [AWidth-1:0] WriteAddress,
    input  logic [DWidth-1:0] DIn,
    output logic              DOutValid,
    output logic [DWidth-1:0] DOut,
    output logic              InitDone
);

    localparam int NBANKS = nbanks(AWidth, BankAWidth);
    localparam int BIW    = log2c(NBANKS);
    localparam logic [BankAWidth-1:0] LAST_ROW = '1;

    if (BankAWidth > AWidth || NBANKS > MAX_BANKS || NBANKS < 1) begin : g_bad_cfg
        $fatal(1, "sram_banked_2p_wrap: unsupported bank geometry");
    end

    state_e                state_q, state_d;
    logic                  pri_q, pri_d;
    logic [BankAWidth-1:0] init_cnt_q, init_cnt_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [BIW-1:0]        rd_bank_q, rd_bank_d;
    logic                  dout_vld_q, dout_vld_d;
    logic [DWidth-1:0]     dout_q, dout_d;

    logic [BIW-1:0]        rb, wb;
    logic                  run, conflict, rd_gnt, wr_gnt;
    logic [NBANKS-1:0]     bank_en, bank_we;
    logic [BankAWidth-1:0] bank_addr [NBANKS];
    logic [DWidth-1:0]     bank_din;
    logic [DWidth-1:0]     bank_dout [NBANKS];
    logic [DWidth-1:0]     rdata;

    assign rb       = BIW'(ReadAddress >> BankAWidth);
    assign wb       = BIW'(WriteAddress >> BankAWidth);
    assign run      = (state_q == ST_RUN);
    assign conflict = ReadValid && WriteValid && (rb == wb);
    assign rd_gnt   = run && ReadValid  && (!conflict ||  pri_q);
    assign wr_gnt   = run && WriteValid && (!conflict || !pri_q);

    assign ReadReady  = rd_gnt;
    assign WriteReady = wr_gnt;
    assign InitDone   = run;

    // During INIT every bank writes zero to the same row in parallel.
    always_comb begin
        bank_en  = '0;
        bank_we  = '0;
        bank_din = (state_q == ST_INIT) ? '0 : DIn;
        for (int b = 0; b < NBANKS; b++) begin
            bank_addr[b] = ReadAddress[BankAWidth-1:0];
            if (state_q == ST_INIT) begin
                bank_en[b]   = 1'b1;
                bank_we[b]   = 1'b1;
                bank_addr[b] = init_cnt_q;
            end else if (wr_gnt && wb == BIW'(b)) begin
                bank_en[b]   = 1'b1;
                bank_we[b]   = 1'b1;
                bank_addr[b] = WriteAddress[BankAWidth-1:0];
            end else if (rd_gnt && rb == BIW'(b)) begin
                bank_en[b]   = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        sram_sp_bank #(
            .DWidth (DWidth),
            .AWidth (BankAWidth)
        ) u_bank (
            .Clock   (Clock),
            .Enable  (bank_en[g]),
            .Write   (bank_we[g]),
            .Address (bank_addr[g]),
            .DIn     (bank_din),
            .DOut    (bank_dout[g])
        );
    end

    always_comb begin
        rdata = bank_dout[rd_bank_q];
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ROW) state_d = ST_RUN;
        end
        pri_d      = pri_q ^ (run && conflict);
        rd_vld_d   = rd_gnt;
        rd_bank_d  = rd_gnt ? rb : rd_bank_q;
        dout_vld_d = rd_vld_q;
        dout_d     = rd_vld_q ? rdata : dout_q;
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q    <= (ZeroInit != 0) ? ST_INIT : ST_RUN;
            pri_q      <= 1'b0;
            init_cnt_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_bank_q  <= '0;
            dout_vld_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            pri_q      <= pri_d;
            init_cnt_q <= init_cnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_bank_q  <= rd_bank_d;
            dout_vld_q <= dout_vld_d;
            dout_q     <= dout_d;
        end
    end

    if (OutReg != 0) begin : g_oreg
        assign DOutValid = dout_vld_q;
        assign DOut      = dout_q;
    end else begin : g_ocomb
        assign DOutValid = rd_vld_q;
        assign DOut      = rd_vld_q ? rdata : '0;
    end

endmodule

// File: tb/tb_sram_banked_2p_wrap.sv
// Bench for sram_banked_2p_wrap: an OutReg=1 and an OutReg=0 instance share stimulus,
// reads are scored against a memory model through per-instance expectation queues.
module tb_sram_banked_2p_wrap;

    logic        Clock = 1'b0;
    logic        Reset_N;
    logic        ReadValid, WriteValid;
    logic [11:0] ReadAddress, WriteAddress;
    logic [63:0] DIn;
    logic        rrdy1, wrdy1, dov1, init1;
    logic        rrdy0, wrdy0, dov0, init0;
    logic [63:0] dout1, dout0;

    always #5 Clock = ~Clock;

    sram_banked_2p_wrap #(.DWidth(64), .AWidth(12), .BankAWidth(10), .OutReg(1), .ZeroInit(1)) u_dut (
        .Clock(Clock), .Reset_N(Reset_N),
        .ReadValid(ReadValid), .ReadReady(rrdy1), .ReadAddress(ReadAddress),
        .WriteValid(WriteValid), .WriteReady(wrdy1), .WriteAddress(WriteAddress), .DIn(DIn),
        .DOutValid(dov1), .DOut(dout1), .InitDone(init1)
    );

    sram_banked_2p_wrap #(.DWidth(64), .AWidth(12), .BankAWidth(10), .OutReg(0), .ZeroInit(1)) u_dut_l1 (
        .Clock(Clock), .Reset_N(Reset_N),
        .ReadValid(ReadValid), .ReadReady(rrdy0), .ReadAddress(ReadAddress),
        .WriteValid(WriteValid), .WriteReady(wrdy0), .WriteAddress(WriteAddress), .DIn(DIn),
        .DOutValid(dov0), .DOut(dout0), .InitDone(init0)
    );

    typedef struct {
        logic [63:0] d;
        int          due;
    } exp_t;

    typedef struct {
        logic        rv;
        logic [11:0] ra;
        logic        wv;
        logic [11:0] wa;
        logic [63:0] din;
        logic        xr;
        logic        xw;
    } vec_t;

    exp_t        q1[$];
    exp_t        q0[$];
    logic [63:0] model [4096];
    logic [63:0] last1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Requester rule: a stalled request holds valid and address.
    assert property (@(posedge Clock) disable iff (!Reset_N)
        (ReadValid && !rrdy1) |=> (ReadValid && $stable(ReadAddress)))
        else $error("stalled read request changed");
    assert property (@(posedge Clock) disable iff (!Reset_N)
        (WriteValid && !wrdy1) |=> (WriteValid && $stable(WriteAddress)))
        else $error("stalled write request changed");

    always @(negedge Clock) begin : mon_l2
        exp_t e;
        if (dov1) begin
            if (q1.size() == 0) chk("rd_l2_spurious", dov1, 1'b0);
            else begin
                e = q1.pop_front();
                chk("rd_l2_data", dout1, e.d);
                chk("rd_l2_latency", cyc, e.due);
                last1 = e.d;
            end
        end else if (q1.size() != 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            chk("rd_l2_missing", dov1, 1'b1);
        end
    end

    always @(negedge Clock) begin : mon_l1
        exp_t e;
        if (dov0) begin
            if (q0.size() == 0) chk("rd_l1_spurious", dov0, 1'b0);
            else begin
                e = q0.pop_front();
                chk("rd_l1_data", dout0, e.d);
                chk("rd_l1_latency", cyc, e.due);
            end
        end else if (q0.size() != 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            chk("rd_l1_missing", dov0, 1'b1);
        end
    end

    // One request cycle: drive, check grants mid-cycle, score, advance past the edge.
    task automatic run_vec(input vec_t v, input string nm);
        ReadValid    = v.rv;
        ReadAddress  = v.ra;
        WriteValid   = v.wv;
        WriteAddress = v.wa;
        DIn          = v.din;
        @(negedge Clock);
        chk({nm, "_rrdy"}, rrdy1, v.xr);
        chk({nm, "_wrdy"}, wrdy1, v.xw);
        chk({nm, "_rrdy_l1"}, rrdy0, v.xr);
        chk({nm, "_wrdy_l1"}, wrdy0, v.xw);
        if (v.rv && v.xr) begin
            q1.push_back('{d: model[v.ra], due: cyc + 2});
            q0.push_back('{d: model[v.ra], due: cyc + 1});
        end
        if (v.wv && v.xw) model[v.wa] = v.din;
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge Clock);
            #1;
            n++;
        end while (!init1 && n < 2000);
        chk(nm, n, 1024);
        chk({nm, "_l1"}, init0, 1'b1);
    endtask

    vec_t vt [15];
    vec_t idle;

    initial begin
        vt[0]  = '{1'b1, 12'hABC, 1'b0, 12'h000, 64'h0,                1'b1, 1'b0};
        vt[1]  = '{1'b0, 12'h000, 1'b1, 12'h123, 64'hDEADBEEF,         1'b0, 1'b1};
        vt[2]  = '{1'b1, 12'h123, 1'b0, 12'h000, 64'h0,                1'b1, 1'b0};
        vt[3]  = '{1'b0, 12'h000, 1'b1, 12'h00F, 64'h1111_0000_0000_1111, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 12'h00F, 1'b1, 12'h405, 64'h2222,             1'b1, 1'b1};
        vt[5]  = '{1'b1, 12'h405, 1'b0, 12'h000, 64'h0,                1'b1, 1'b0};
        vt[6]  = '{1'b1, 12'h801, 1'b1, 12'h802, 64'h3333,             1'b0, 1'b1};
        vt[7]  = '{1'b1, 12'h801, 1'b1, 12'h802, 64'h3333,             1'b1, 1'b0};
        vt[8]  = '{1'b1, 12'h801, 1'b1, 12'h802, 64'h3333,             1'b0, 1'b1};
        vt[9]  = '{1'b1, 12'h801, 1'b1, 12'h802, 64'h3333,             1'b1, 1'b0};
        vt[10] = '{1'b0, 12'h000, 1'b1, 12'h802, 64'h3333,             1'b0, 1'b1};
        vt[11] = '{1'b1, 12'h7FF, 1'b1, 12'h7FF, 64'h4444_5555,        1'b0, 1'b1};
        vt[12] = '{1'b1, 12'h7FF, 1'b0, 12'h000, 64'h0,                1'b1, 1'b0};
        vt[13] = '{1'b1, 12'h802, 1'b0, 12'h000, 64'h0,                1'b1, 1'b0};
        vt[14] = '{1'b0, 12'h000, 1'b0, 12'h000, 64'h0,                1'b0, 1'b0};
        idle   = vt[14];
        for (int i = 0; i < 4096; i++) model[i] = 64'h0;
        last1 = 64'h0;

        Reset_N = 1'b0; ReadValid = 1'b0; WriteValid = 1'b0;
        ReadAddress = '0; WriteAddress = '0; DIn = '0;
        #2;
        chk("rst_dov", dov1, 1'b0);
        chk("rst_dout", dout1, 64'h0);
        chk("rst_init", init1, 1'b0);
        chk("rst_dov_l1", dov0, 1'b0);
        chk("rst_init_l1", init0, 1'b0);
        repeat (2) @(posedge Clock);
        #1;
        Reset_N = 1'b1;
        wait_init("init_cycles");

        for (int i = 0; i < 15; i++) run_vec(vt[i], $sformatf("vec%0d", i));
        repeat (4) run_vec(idle, "idle");
        chk("drain", (q1.size() == 0 && q0.size() == 0), 1'b1);
        chk("hold_dov", dov1, 1'b0);
        chk("hold_dout", dout1, last1);
        chk("hold_value", last1, 64'h3333);

        // Two reads in flight when reset hits: both must vanish.
        run_vec('{1'b1, 12'h123, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0}, "rst_rd_a");
        run_vec('{1'b1, 12'h405, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0}, "rst_rd_b");
        q1.delete();
        q0.delete();
        Reset_N = 1'b0;
        #1;
        chk("rst_mid_rrdy", rrdy1, 1'b0);
        chk("rst_mid_rrdy_l1", rrdy0, 1'b0);
        chk("rst_mid_dov", dov1, 1'b0);
        chk("rst_mid_dov_l1", dov0, 1'b0);
        chk("rst_mid_init", init1, 1'b0);
        ReadValid = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        Reset_N = 1'b1;
        wait_init("init_restart");
        for (int i = 0; i < 4096; i++) model[i] = 64'h0;
        run_vec('{1'b1, 12'h123, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0}, "post_rst_rd");
        repeat (3) run_vec(idle, "idle2");
        chk("drain2", (q1.size() == 0 && q0.size() == 0), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
